// File: rtl/ram_access_ctrl_if.sv
// Bus between the multicore system top (master) and ram_access_ctrl (slave).
// Handshake: memREN/memWEN are level requests held with stable memaddr/memstore until ramstate reads ACCESS.
interface ram_access_ctrl_if;
  logic [31:0] memaddr;
  logic [31:0] memstore;
  logic        memREN;
  logic        memWEN;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output memaddr, memstore, memREN, memWEN,
    input  ramload, ramstate
  );

  modport slave (
    input  memaddr, memstore, memREN, memWEN,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Word-addressed RAM behind a latency-emulating FSM (IDLE -> WAIT -> ACC).
// Define RAM_ACCESS_ERROR_EN to trap dual-enable and out-of-range addresses in an ERR state.
module ram_access_ctrl #(
  parameter int LAT   = 2,
  parameter int DEPTH = 16384
) (
  input  logic              CLK,
  input  logic              nRST,
  ram_access_ctrl_if.slave  bus,
  output logic [1:0]        o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_V = 4'(LAT);

  // Encodings match ramstate directly: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACC = 2'd2, ERR = 2'd3} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt;
  logic [31:0] r_addr, r_data, r_ramload;
  logic        r_ren, r_wen;
  logic        w_latch, w_acc, w_req, w_err, w_diff;
  logic [AW-1:0] w_idx;
  logic [31:0] r_mem [DEPTH];

  assign w_idx  = bus.memaddr[AW+1:2];
  assign w_req  = bus.memREN | bus.memWEN;
  assign w_diff = (bus.memaddr != r_addr) || (bus.memstore != r_data) ||
                  (bus.memREN != r_ren) || (bus.memWEN != r_wen);
`ifdef RAM_ACCESS_ERROR_EN
  assign w_err  = (bus.memREN & bus.memWEN) || (bus.memaddr[31:AW+2] != '0);
`else
  assign w_err  = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_latch = 1'b0;
    w_acc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_err) begin
            w_next = ERR;
          end else begin
            w_latch = 1'b1;
            w_cnt   = LAT_V;
            if (LAT == 0) begin
              w_next = ACC;
              w_acc  = 1'b1;
            end else begin
              w_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_next = IDLE;
          w_cnt  = '0;
        end else if (w_err) begin
          w_next = ERR;
          w_cnt  = '0;
        end else if (w_diff) begin
          // Request changed under us: start the wait over on the new values.
          w_latch = 1'b1;
          w_cnt   = LAT_V;
        end else if (r_cnt == 4'd1) begin
          w_next = ACC;
          w_acc  = 1'b1;
          w_cnt  = '0;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      ACC:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_ramload <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_latch) begin
        r_addr <= bus.memaddr;
        r_data <= bus.memstore;
        r_ren  <= bus.memREN;
        r_wen  <= bus.memWEN;
      end
      // Write wins when both enables are high, so only a pure read loads ramload.
      if (w_acc && bus.memREN && !bus.memWEN) r_ramload <= r_mem[w_idx];
    end
  end

  // Array has no reset; gating on nRST keeps a held request from writing during reset.
  always_ff @(posedge CLK) begin
    if (nRST && w_acc && bus.memWEN) r_mem[w_idx] <= bus.memstore;
  end

  assign bus.ramload  = r_ramload;
  assign bus.ramstate = r_state;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: three instances at LAT=2, LAT=0 and LAT=3.
module tb_ram_access_ctrl;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        clk = 1'b0;
  logic        nrst;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ld2;
  logic [1:0]  dbg2, dbg0, dbg3;

  always #5 clk = ~clk;

  ram_access_ctrl_if b2 ();
  ram_access_ctrl_if b0 ();
  ram_access_ctrl_if b3 ();

  ram_access_ctrl #(.LAT(2)) u2 (.CLK(clk), .nRST(nrst), .bus(b2.slave), .o_dbg_state(dbg2));
  ram_access_ctrl #(.LAT(0)) u0 (.CLK(clk), .nRST(nrst), .bus(b0.slave), .o_dbg_state(dbg0));
  ram_access_ctrl #(.LAT(3)) u3 (.CLK(clk), .nRST(nrst), .bus(b3.slave), .o_dbg_state(dbg3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive2(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
    b2.memaddr = a; b2.memstore = d; b2.memREN = r; b2.memWEN = w;
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
    b0.memaddr = a; b0.memstore = d; b0.memREN = r; b0.memWEN = w;
  endtask

  task automatic drive3(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
    b3.memaddr = a; b3.memstore = d; b3.memREN = r; b3.memWEN = w;
  endtask

  initial begin
    nrst = 1'b0;
    drive2('0, '0, 1'b0, 1'b0);
    drive0('0, '0, 1'b0, 1'b0);
    drive3('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_state2", 32'(b2.ramstate), 32'(FREE));
    chk("rst_load2",  b2.ramload, 32'h0);
    chk("rst_dbg2",   32'(dbg2), 32'(FREE));
    chk("rst_state0", 32'(b0.ramstate), 32'(FREE));
    chk("rst_load0",  b0.ramload, 32'h0);
    chk("rst_state3", 32'(b3.ramstate), 32'(FREE));
    chk("rst_load3",  b3.ramload, 32'h0);
    nrst = 1'b1;

    // LAT=2 write 0x40 held until ACCESS
    drive2(32'h40, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("w40_s0", 32'(b2.ramstate), 32'(FREE));
    tick(); chk("w40_s1", 32'(b2.ramstate), 32'(BUSY));
    tick(); chk("w40_s2", 32'(b2.ramstate), 32'(BUSY));
    tick(); chk("w40_s3", 32'(b2.ramstate), 32'(ACCESS));
    chk("w40_load_kept", b2.ramload, 32'h0);
    drive2('0, '0, 1'b0, 1'b0);
    tick(); chk("w40_s4", 32'(b2.ramstate), 32'(FREE));

    // LAT=2 read back 0x40
    drive2(32'h40, '0, 1'b1, 1'b0);
    tick(); chk("r40_s1", 32'(b2.ramstate), 32'(BUSY));
    tick(); chk("r40_s2", 32'(b2.ramstate), 32'(BUSY));
    tick(); chk("r40_s3", 32'(b2.ramstate), 32'(ACCESS));
    chk("r40_load", b2.ramload, 32'hDEADBEEF);
    drive2('0, '0, 1'b0, 1'b0);
    tick(); chk("r40_s4", 32'(b2.ramstate), 32'(FREE));
    chk("r40_load_hold", b2.ramload, 32'hDEADBEEF);

    // Preload 0x44, then read 0x40 and switch to 0x44 after one BUSY cycle
    drive2(32'h44, 32'hCAFEF00D, 1'b0, 1'b1);
    tick(); tick(); tick(); chk("w44_acc", 32'(b2.ramstate), 32'(ACCESS));
    drive2('0, '0, 1'b0, 1'b0);
    tick();
    drive2(32'h40, '0, 1'b1, 1'b0);
    tick(); chk("chg_s1", 32'(b2.ramstate), 32'(BUSY));
    b2.memaddr = 32'h44;
    tick(); chk("chg_e1", 32'(b2.ramstate), 32'(BUSY));
    tick(); chk("chg_e2", 32'(b2.ramstate), 32'(BUSY));
    tick(); chk("chg_e3", 32'(b2.ramstate), 32'(ACCESS));
    chk("chg_load", b2.ramload, 32'hCAFEF00D);
    drive2('0, '0, 1'b0, 1'b0);
    tick();

    // Dropping both enables in WAIT aborts the write
    drive2(32'h48, 32'hAAAA0001, 1'b0, 1'b1);
    tick(); tick(); tick(); chk("w48_acc", 32'(b2.ramstate), 32'(ACCESS));
    drive2('0, '0, 1'b0, 1'b0);
    tick();
    drive2(32'h48, 32'hBBBB0002, 1'b0, 1'b1);
    tick(); chk("abort_busy", 32'(b2.ramstate), 32'(BUSY));
    drive2('0, '0, 1'b0, 1'b0);
    tick(); chk("abort_free", 32'(b2.ramstate), 32'(FREE));
    drive2(32'h48, '0, 1'b1, 1'b0);
    tick(); tick(); tick(); chk("r48_acc", 32'(b2.ramstate), 32'(ACCESS));
    chk("r48_load", b2.ramload, 32'hAAAA0001);
    ld2 = 32'hAAAA0001;
    drive2('0, '0, 1'b0, 1'b0);
    tick();

    // High address bits: wrap by default, ERR with the option
    drive2(32'h0001_0043, '0, 1'b1, 1'b0);
`ifdef RAM_ACCESS_ERROR_EN
    tick(); chk("hi_err", 32'(b2.ramstate), 32'(ERROR));
    chk("hi_load", b2.ramload, ld2);
    drive2('0, '0, 1'b0, 1'b0);
    tick(); chk("hi_free", 32'(b2.ramstate), 32'(FREE));
`else
    tick(); tick(); tick(); chk("wrap_acc", 32'(b2.ramstate), 32'(ACCESS));
    chk("wrap_load", b2.ramload, 32'hDEADBEEF);
    ld2 = 32'hDEADBEEF;
    drive2('0, '0, 1'b0, 1'b0);
    tick();
`endif

    // Both enables high at 0x0
    drive2(32'h0, 32'h5A5A5A5A, 1'b1, 1'b1);
`ifdef RAM_ACCESS_ERROR_EN
    tick(); chk("both_err", 32'(b2.ramstate), 32'(ERROR));
    chk("both_load", b2.ramload, ld2);
    drive2('0, '0, 1'b0, 1'b0);
    tick(); chk("both_free", 32'(b2.ramstate), 32'(FREE));
`else
    tick(); chk("both_s1", 32'(b2.ramstate), 32'(BUSY));
    tick(); tick(); chk("both_acc", 32'(b2.ramstate), 32'(ACCESS));
    chk("both_load_kept", b2.ramload, ld2);
    drive2('0, '0, 1'b0, 1'b0);
    tick();
    drive2(32'h0, '0, 1'b1, 1'b0);
    tick(); tick(); tick(); chk("r0_acc", 32'(b2.ramstate), 32'(ACCESS));
    chk("r0_load", b2.ramload, 32'h5A5A5A5A);
    drive2('0, '0, 1'b0, 1'b0);
    tick();
`endif

    // LAT=0: one edge to ACCESS, no BUSY
    drive0(32'h0, 32'h0F0F0F0F, 1'b0, 1'b1);
    tick(); chk("l0_w_acc", 32'(b0.ramstate), 32'(ACCESS));
    drive0('0, '0, 1'b0, 1'b0);
    tick(); chk("l0_w_free", 32'(b0.ramstate), 32'(FREE));
    drive0(32'h0, '0, 1'b1, 1'b0);
    tick(); chk("l0_r_acc", 32'(b0.ramstate), 32'(ACCESS));
    chk("l0_r_load", b0.ramload, 32'h0F0F0F0F);
    drive0('0, '0, 1'b0, 1'b0);
    tick(); chk("l0_r_free", 32'(b0.ramstate), 32'(FREE));

    // LAT=3: preload 0x80, then reset in the 2nd BUSY cycle of a new write
    drive3(32'h80, 32'h77777777, 1'b0, 1'b1);
    tick(); chk("l3_s1", 32'(b3.ramstate), 32'(BUSY));
    tick(); chk("l3_s2", 32'(b3.ramstate), 32'(BUSY));
    tick(); chk("l3_s3", 32'(b3.ramstate), 32'(BUSY));
    tick(); chk("l3_acc", 32'(b3.ramstate), 32'(ACCESS));
    drive3('0, '0, 1'b0, 1'b0);
    tick();
    drive3(32'h80, 32'h12345678, 1'b0, 1'b1);
    tick(); tick(); chk("l3_busy2", 32'(b3.ramstate), 32'(BUSY));
    #2 nrst = 1'b0;
    #1;
    chk("arst_state3", 32'(b3.ramstate), 32'(FREE));
    chk("arst_dbg3",   32'(dbg3), 32'(FREE));
    chk("arst_load3",  b3.ramload, 32'h0);
    chk("arst_load2",  b2.ramload, 32'h0);
    tick(); chk("arst_hold3", 32'(b3.ramstate), 32'(FREE));
    drive3('0, '0, 1'b0, 1'b0);
    nrst = 1'b1;
    tick();
    drive3(32'h80, '0, 1'b1, 1'b0);
    tick(); tick(); tick(); tick(); chk("l3_r_acc", 32'(b3.ramstate), 32'(ACCESS));
    chk("l3_r_load", b3.ramload, 32'h77777777);
    drive3('0, '0, 1'b0, 1'b0);
    tick(); chk("l3_r_free", 32'(b3.ramstate), 32'(FREE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter LAT, default 2: wait cycles between request capture and ACCESS (legal range 0..15).
REQ-002 Parameter DEPTH, default 16384: number of 32-bit words in the array; AW = clog2(DEPTH).
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 memaddr  input  32  byte address from the multicore system top.
REQ-006 memstore  input  32  write data.
REQ-007 memREN  input  1  read request, level.
REQ-008 memWEN  input  1  write request, level.
REQ-009 ramload  output  32  read data, registered.
REQ-010 ramstate  output  2  encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3; registered.

Function
REQ-011 The block SHALL hold a DEPTH x 32 array indexed by memaddr[AW+1:2]; memaddr[1:0] and bits above AW+1 are ignored (address wrap).
REQ-012 The FSM SHALL have states IDLE, WAIT, ACC; ramstate SHALL be FREE in IDLE, BUSY in WAIT, ACCESS in ACC.
REQ-013 IDLE: at an edge with memREN or memWEN high, the block SHALL latch addr, data and op, load counter = LAT, and go to WAIT, or go directly to ACC if LAT = 0.
REQ-014 WAIT: the counter SHALL decrement by 1 per edge; at the edge where it equals 1, the FSM SHALL go to ACC.
REQ-015 WAIT: if memaddr, memstore, memREN or memWEN differs from the latched values, the FSM SHALL relatch and restart the counter at LAT without entering ACC.
REQ-016 WAIT: if both enables are low, the FSM SHALL return to IDLE and no array write occurs.
REQ-017 On the edge entering ACC:
- read: the block SHALL register array[idx] into ramload.
- write: the block SHALL write memstore into array[idx]. ramload is unchanged.
REQ-018 ACC SHALL last exactly one cycle, then return to IDLE; a request still held is treated as a new request. Total request-to-ACCESS latency is LAT+1 edges.
REQ-019 When both memREN and memWEN are high (macro undefined), the write SHALL take priority and ramload SHALL keep its previous value.
REQ-020 The array SHALL have no reset; contents are undefined until written.

Reset
REQ-021 While nRST is low:
- FSM = IDLE, counter = 0, latched registers = 0.
- ramstate = FREE, ramload = 32'h0.
REQ-022 Reset asserted during WAIT SHALL abort the request and leave the array unchanged.

Configuration
REQ-023 Macro RAM_ACCESS_ERROR_EN, when defined, SHALL add state ERR (ramstate = ERROR).
- ERR is entered from IDLE or WAIT when both enables are high, or when memaddr[31:AW+2] is nonzero.
- ERR is held for one cycle, then the FSM returns to IDLE.
- No array write occurs, and ramload is unchanged.
REQ-024 Without RAM_ACCESS_ERROR_EN:
- ERROR SHALL never be output.
- Address wrap per REQ-011 applies.
- Write priority per REQ-019 applies.

Verification
REQ-025 LAT=2, write addr 0x40 data 0xDEADBEEF, held until ACCESS -> ramstate sequence FREE, BUSY, BUSY, ACCESS, FREE; array[16]=0xDEADBEEF.
REQ-026 LAT=2, read addr 0x40 after REQ-025 -> ACCESS on the 3rd edge, ramload=0xDEADBEEF in the same cycle.
REQ-027 LAT=2, read 0x40, addr changed to 0x44 after 1 BUSY cycle -> counter restarts; ACCESS occurs 3 edges after the change with array[17] data.
REQ-028 LAT=0, read 0x0 -> ACCESS on the first edge after request, BUSY never seen.
REQ-029 LAT=3, write 0x80 data 0x12345678, nRST pulsed low in 2nd BUSY cycle -> ramstate=FREE and ramload=0 asynchronously; array[32] unchanged.
REQ-030 With RAM_ACCESS_ERROR_EN, memREN=memWEN=1 at 0x0 -> ERROR for one cycle, then FREE; without the macro -> write of memstore after LAT+1 edges.
